// File: rtl/sonar_array_if.sv
// sonar_array_if - pin and result bundle for sonar_array_ctrl.
//
// Signals:
//   enable          scan request (master -> slave)
//   echo[N_CH]      raw echo inputs (master -> slave)
//   trig[N_CH]      trigger outputs, at most one high
//   distance_mm     latched distances, channel i at [i*DIST_W +: DIST_W]
//   dist_valid      one-cycle update strobe per channel
//   timeout         last measurement of the channel timed out
//   near, stop      hysteretic proximity flags and their registered OR
//   min_distance_mm, min_ch   smallest latched distance and its channel
//   busy            controller is not idle
//
// master: the environment (pins / testbench); slave: the controller.
interface sonar_array_if #(
    parameter int N_CH   = 4,
    parameter int DIST_W = 12,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic                   enable;
    logic [N_CH-1:0]        echo;
    logic [N_CH-1:0]        trig;
    logic [N_CH*DIST_W-1:0] distance_mm;
    logic [N_CH-1:0]        dist_valid;
    logic [N_CH-1:0]        timeout;
    logic [N_CH-1:0]        near;
    logic                   stop;
    logic [DIST_W-1:0]      min_distance_mm;
    logic [CH_W-1:0]        min_ch;
    logic                   busy;

    modport master (
        output enable, echo,
        input  trig, distance_mm, dist_valid, timeout, near, stop,
               min_distance_mm, min_ch, busy
    );

    modport slave (
        input  enable, echo,
        output trig, distance_mm, dist_valid, timeout, near, stop,
               min_distance_mm, min_ch, busy
    );
endinterface

// File: rtl/sonar_array_ctrl.sv
// sonar_array_ctrl - round-robin HC-SR04 ranging controller for N_CH sensors.
//
// One channel slot at a time: trigger pulse, echo-high measurement (with a
// timeout), one-cycle result latch, then a quiet gap before the next channel.
// Produces per-channel distances in mm, hysteretic near flags, an aggregated
// stop, and optionally the minimum distance across channels.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    sonar_array_if.slave (enable/echo in, trig/results out)
//
// Build option: define SONAR_MIN_TRACK_EN to build the registered minimum
// tracker; otherwise min_distance_mm is all-ones and min_ch is 0.
module sonar_array_ctrl #(
    parameter int N_CH        = 4,
    parameter int DIST_W      = 12,
    parameter int TRIG_CYC    = 500,
    parameter int CYC_PER_MM  = 291,
    parameter int TIMEOUT_CYC = 1_500_000,
    parameter int GAP_CYC     = 500_000,
    parameter int THRESH_MM   = 1000,
    parameter int HYST_MM     = 50,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input logic           clk,
    input logic           rst_n,
    sonar_array_if.slave  bus
);
    localparam int CNT_MAX = (TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int SUB_W   = $clog2(CYC_PER_MM + 1);

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYC_PER_MM - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);
    localparam logic [DIST_W:0]   NEAR_SET  = (DIST_W+1)'(THRESH_MM);
    localparam logic [DIST_W:0]   NEAR_CLR  = (DIST_W+1)'(THRESH_MM + HYST_MM);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE, GAP} state_t;
    state_t state, state_nx;

    logic [N_CH-1:0]              echo_m, echo_s;
    logic [CH_W-1:0]              ch;
    logic [CNT_W-1:0]             cnt;
    logic [TO_W-1:0]              to_cnt;
    logic [SUB_W-1:0]             sub;
    logic [DIST_W-1:0]            mm;
    logic                         to_hit;
    logic [N_CH-1:0]              trig_q, dv_q, to_q, near_q;
    logic [N_CH-1:0][DIST_W-1:0]  dist_q;
    logic                         stop_q;
    logic                         echo_cur, to_now;
    logic [DIST_W-1:0]            result;

    assign echo_cur = echo_s[ch];
    // Timeout wins over a simultaneous rising edge; a falling edge on the
    // last cycle still counts as a good measurement.
    assign to_now   = (to_cnt == TO_LAST) &&
                      ((state == WAIT_RISE) || (state == MEASURE && echo_cur));
    assign result   = to_hit ? '1 : mm;

    // echo pins are asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_m <= '0;
            echo_s <= '0;
        end else begin
            echo_m <= bus.echo;
            echo_s <= echo_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (bus.enable) state_nx = TRIG;
            TRIG:      if (cnt == TRIG_LAST) state_nx = WAIT_RISE;
            WAIT_RISE: if (to_now) state_nx = DONE;
                       else if (echo_cur) state_nx = MEASURE;
            MEASURE:   if (!echo_cur || to_now) state_nx = DONE;
            DONE:      state_nx = GAP;
            GAP:       if (cnt == GAP_LAST) state_nx = bus.enable ? TRIG : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Slot datapath: phase counter, timeout counter, mm divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            to_cnt <= '0;
            sub    <= '0;
            mm     <= '0;
            to_hit <= 1'b0;
            ch     <= '0;
        end else begin
            unique case (state)
                TRIG: begin
                    cnt    <= (cnt == TRIG_LAST) ? '0 : cnt + 1'b1;
                    to_cnt <= '0;
                    sub    <= '0;
                    mm     <= '0;
                    to_hit <= 1'b0;
                end
                // Counting also runs in WAIT_RISE so the first synchronised
                // high cycle (or a stale high on entry) is included.
                WAIT_RISE, MEASURE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (to_now) to_hit <= 1'b1;
                    if (echo_cur) begin
                        if (sub == SUB_LAST) begin
                            sub <= '0;
                            if (mm != '1) mm <= mm + 1'b1;
                        end else begin
                            sub <= sub + 1'b1;
                        end
                    end
                end
                GAP: begin
                    cnt <= (cnt == GAP_LAST) ? '0 : cnt + 1'b1;
                    if (cnt == GAP_LAST) ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result registers: all visible the cycle after DONE; stop one later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= '0;
            dv_q   <= '0;
            to_q   <= '0;
            near_q <= '0;
            dist_q <= '1;
            stop_q <= 1'b0;
        end else begin
            trig_q <= (state == TRIG) ? (N_CH'(1) << ch) : '0;
            dv_q   <= '0;
            stop_q <= |near_q;
            if (state == DONE) begin
                dist_q[ch] <= result;
                dv_q[ch]   <= 1'b1;
                to_q[ch]   <= to_hit;
                if ({1'b0, result} < NEAR_SET)       near_q[ch] <= 1'b1;
                else if ({1'b0, result} >= NEAR_CLR) near_q[ch] <= 1'b0;
            end
        end
    end

`ifdef SONAR_MIN_TRACK_EN
    logic [DIST_W-1:0] min_d_c, min_d_q;
    logic [CH_W-1:0]   min_ch_c, min_ch_q;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_d_c  = dist_q[0];
        min_ch_c = '0;
        for (int i = 1; i < N_CH; i++) begin
            if (dist_q[i] < min_d_c) begin
                min_d_c  = dist_q[i];
                min_ch_c = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_d_q  <= '1;
            min_ch_q <= '0;
        end else if (|dv_q) begin
            min_d_q  <= min_d_c;
            min_ch_q <= min_ch_c;
        end
    end

    assign bus.min_distance_mm = min_d_q;
    assign bus.min_ch          = min_ch_q;
`else
    assign bus.min_distance_mm = '1;
    assign bus.min_ch          = '0;
`endif

    assign bus.trig        = trig_q;
    assign bus.distance_mm = dist_q;
    assign bus.dist_valid  = dv_q;
    assign bus.timeout     = to_q;
    assign bus.near        = near_q;
    assign bus.stop        = stop_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: doc/sonar_array_ctrl.md
# sonar_array_ctrl

Multi-channel HC-SR04 ranging controller, the successor to the single-sensor sonar ranging and obstacle-detect path. Time-multiplexes N_CH ultrasonic sensors round-robin: one trigger pulse, echo measurement and timeout per channel slot, so sensors never fire concurrently. Produces latched per-channel distances in millimetres, per-channel near flags with hysteresis, and an aggregated `stop` for the motion controller. It sits between the GPIO pins and the display/drive logic and runs directly on the 50 MHz system clock, so no dedicated sonar PLL is required.

## Interface
Parameters:
- `N_CH`, 4: number of sensors (1–8).
- `DIST_W`, 12: distance width in mm.
- `TRIG_CYC`, 500: trigger high time in clocks (10 µs at 50 MHz).
- `CYC_PER_MM`, 291: echo-high clocks per 1 mm of range.
- `TIMEOUT_CYC`, 1_500_000: maximum clocks from trigger fall to echo fall.
- `GAP_CYC`, 500_000: quiet time after each slot, before the next channel is triggered.
- `THRESH_MM`, 1000: near threshold.
- `HYST_MM`, 50: release hysteresis.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  run scanning while high.
- `echo`  in  N_CH  raw asynchronous echo inputs.
- `trig`  out  N_CH  trigger outputs, at most one high at a time.
- `distance_mm`  out  N_CH*DIST_W  latched distance; channel i occupies bits [i*DIST_W +: DIST_W].
- `dist_valid`  out  N_CH  one-cycle pulse when the channel's distance updates.
- `timeout`  out  N_CH  set when the channel's last measurement timed out; cleared by its next good measurement.
- `near`  out  N_CH  hysteretic proximity flag.
- `stop`  out  1  OR of `near`.
- `min_distance_mm`  out  DIST_W  smallest latched distance (see Configuration).
- `min_ch`  out  $clog2(N_CH)  index of that channel.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Echo inputs pass through a 2-FF synchroniser; all echo timing below refers to the synchronised signal.
- FSM states:
  - IDLE: entered from reset. Goes to TRIG when `enable`=1.
  - TRIG: `trig[ch]` high for exactly TRIG_CYC cycles, then WAIT_RISE.
  - WAIT_RISE: waits for echo high, then MEASURE.
  - MEASURE: counts echo-high time; echo fall goes to DONE.
  - DONE: 1 cycle; latches the result, then GAP.
  - GAP: waits GAP_CYC cycles. Then ch advances (N_CH-1 wraps to 0) and the FSM goes to TRIG if `enable`=1, otherwise to IDLE.
- Distance counting: a sub-counter divides echo-high cycles by CYC_PER_MM; the mm counter increments on each wrap. The mm counter saturates at 2^DIST_W-1 and does not wrap.
- Timeout: one counter runs from entry to WAIT_RISE through MEASURE. Reaching TIMEOUT_CYC forces DONE with result all-ones and sets `timeout[ch]`.
- `near` is updated only in DONE:
  - set if result < THRESH_MM;
  - cleared if result >= THRESH_MM+HYST_MM;
  - otherwise held.
  - A timeout result therefore clears `near`.
- Deasserting `enable` mid-slot does not abort the slot. The slot completes, including GAP, before the FSM enters IDLE.
- Echo already high on entry to WAIT_RISE, from a stale reflection: treated as the rising edge.
- Reset values:
  - `trig`=0, `dist_valid`=0, `near`=0, `stop`=0, `busy`=0;
  - `distance_mm` all-ones on every channel;
  - `timeout`=0;
  - `min_distance_mm` all-ones, `min_ch`=0;
  - ch=0.
  - Reset mid-slot drops `trig` immediately, because reset is asynchronous.

## Timing
- `trig` rises 1 cycle after TRIG entry. First trigger after `enable` rises: cycle 2.
- Echo-to-count latency is 2 cycles (synchroniser); the end of measurement carries the same offset.
- `distance_mm`, `timeout` and `dist_valid` change in the same cycle, 1 cycle after DONE.
- `near` changes in that same cycle. `stop` follows 1 cycle later, registered.
- `min_distance_mm` and `min_ch` update 1 cycle after `dist_valid`.
- Ties resolve to the lowest index.
- Slot period = TRIG_CYC + echo/timeout time + 1 + GAP_CYC + 1.

## Configuration
- `SONAR_MIN_TRACK_EN` defined: the registered minimum tracker is built. It compares all N_CH latched distances after every update.
- Not defined: `min_distance_mm` is tied to all-ones, `min_ch` is tied to 0, and no comparator tree is synthesised.

## Test plan
Benches use TRIG_CYC=10, CYC_PER_MM=10, TIMEOUT_CYC=50_000, GAP_CYC=100, N_CH=4.
- Enable, echo[0] high 5000 cycles → `trig[0]` pulse of 10 cycles; `distance_mm[0]`=500; `near[0]`=1; `stop`=1.
- Channel 1 never echoes → `distance_mm[1]`=4095, `timeout[1]`=1, `near[1]`=0; the scan continues on channel 2.
- Channel 0 sequence 990 → 1020 → 1060 mm → `near[0]` = 1, 1, 0 respectively.
- Distances 800/300/300/900 (with `SONAR_MIN_TRACK_EN`) → `min_distance_mm`=300, `min_ch`=1.
- Drop `enable` during a channel 2 MEASURE → channel 2 result is latched, GAP completes, then IDLE with `busy`=0 and no `trig[3]`.
- Assert `rst_n`=0 while `trig` is high → all outputs return to reset values asynchronously; after release with `enable`=1, scanning restarts at channel 0.
